// File: rtl/skew_feeder.sv
// rtl/skew_feeder.sv - pulls one activation tile and skews it into a diagonal wavefront
// Lane i runs through an i-stage delay line ahead of its output register.
module skew_feeder #(
    parameter int DWIDTH     = 8,
    parameter int LANES_LOG2 = 2,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  rd_rdy,
    input  logic [(1<<LANES_LOG2)*DWIDTH-1:0]     rd_data,
    output logic                                  rd_acq,
    input  logic                                  out_en,
    output logic [(1<<LANES_LOG2)*DWIDTH-1:0]     out_data,
    output logic [(1<<LANES_LOG2)-1:0]            out_valid,
    output logic                                  busy,
    output logic                                  done
);

    localparam int LANES = 1 << LANES_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int DCW   = (LANES_LOG2 > 1) ? LANES_LOG2 : 1;

    localparam logic [DEPTH_LOG2-1:0] VEC_LAST   = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [DEPTH_LOG2-1:0] VEC_ONE    = DEPTH_LOG2'(1);
    localparam logic [DCW-1:0]        DRAIN_LAST = DCW'(LANES - 2);
    localparam logic [DCW-1:0]        DRAIN_ONE  = DCW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    logic [DEPTH_LOG2-1:0] vec_cnt_q;
    logic [DCW-1:0]        drain_cnt_q;
    logic                  done_q;
    logic                  accept;

    assign rd_acq = (state_q == LOAD) && out_en && rd_rdy;
    assign accept = rd_acq;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

    // Every state change rides on an advance, so a stalled array freezes the FSM too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_cnt_q   <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (out_en) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q   <= LOAD;
                            vec_cnt_q <= '0;
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            if (vec_cnt_q == VEC_LAST) begin
                                vec_cnt_q <= '0;
                                if (LANES > 1) begin
                                    state_q     <= DRAIN;
                                    drain_cnt_q <= '0;
                                end else begin
                                    state_q <= IDLE;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                vec_cnt_q <= vec_cnt_q + VEC_ONE;
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt_q == DRAIN_LAST) begin
                            state_q     <= IDLE;
                            drain_cnt_q <= '0;
                            done_q      <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Stage i is the output register; stages below it form the skew delay.
        logic [i:0][DWIDTH-1:0] dat_q;
        logic [i:0]             vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dat_q <= '0;
                vld_q <= '0;
            end else if (out_en) begin
                dat_q[0] <= accept ? rd_data[i*DWIDTH +: DWIDTH] : '0;
                vld_q[0] <= accept;
                for (int j = 1; j <= i; j++) begin
                    dat_q[j] <= dat_q[j-1];
                    vld_q[j] <= vld_q[j-1];
                end
            end
        end

        assign out_data[i*DWIDTH +: DWIDTH] = dat_q[i];
        assign out_valid[i]                 = vld_q[i];
    end

endmodule

// File: tb/tb_skew_feeder.sv
// tb/tb_skew_feeder.sv - directed table plus random scoreboard bench for skew_feeder
module tb_skew_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rd_rdy = 1'b0;
    logic [31:0] rd_data = '0;
    logic        rd_acq;
    logic        out_en = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        busy;
    logic        done;

    skew_feeder #(.DWIDTH(8), .LANES_LOG2(2), .DEPTH_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_rdy(rd_rdy), .rd_data(rd_data),
        .rd_acq(rd_acq), .out_en(out_en), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vec_idx = 0;

    logic [31:0] acq_m, done_m, busy_m;
    logic [3:0]  obs_valid [32];
    logic [31:0] obs_data  [32];

    typedef struct {
        logic        s, r, e;
        logic        acq, bsy, dn;
        logic [3:0]  vld;
        logic [31:0] dat;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_vec(input int v);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(16 * v + i);
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; rd_rdy = 1'b0; out_en = 1'b0; rd_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        vec_idx = 0;
    endtask

    task automatic step(input logic s, input logic r, input logic e);
        start = s; rd_rdy = r; out_en = e; rd_data = mk_vec(vec_idx);
        @(negedge clk);
    endtask

    task automatic finish_step();
        if (rd_acq) vec_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pattern(input int n, input logic [31:0] sm, input logic [31:0] rm,
                               input logic [31:0] em);
        acq_m = '0; done_m = '0; busy_m = '0;
        for (int c = 0; c < n; c++) begin
            step(sm[c], rm[c], em[c]);
            acq_m[c] = rd_acq; done_m[c] = done; busy_m[c] = busy;
            obs_valid[c] = out_valid; obs_data[c] = out_data;
            finish_step();
        end
    endtask

    logic [7:0] q_lane [4][$];
    int         g_acc;
    int         tiles_started;
    int         dones;
    int         cyc;
    logic [7:0] exp_e;
    logic       s_r, r_r, e_r;

    initial begin
        tbl[0] = '{1, 1, 1, 0, 0, 0, 4'b0000, 32'h00000000};
        tbl[1] = '{0, 1, 1, 1, 1, 0, 4'b0000, 32'h00000000};
        tbl[2] = '{0, 1, 1, 1, 1, 0, 4'b0001, 32'h00000000};
        tbl[3] = '{0, 1, 1, 1, 1, 0, 4'b0011, 32'h00000110};
        tbl[4] = '{0, 1, 1, 1, 1, 0, 4'b0111, 32'h00021120};
        tbl[5] = '{0, 1, 1, 0, 1, 0, 4'b1111, 32'h03122130};
        tbl[6] = '{0, 1, 1, 0, 1, 0, 4'b1110, 32'h13223100};
        tbl[7] = '{0, 1, 1, 0, 1, 0, 4'b1100, 32'h23320000};
        tbl[8] = '{0, 1, 1, 0, 0, 1, 4'b1000, 32'h33000000};
        tbl[9] = '{0, 1, 1, 0, 0, 0, 4'b0000, 32'h00000000};

        do_reset();
        @(negedge clk);
        chk("reset_valid", {28'd0, out_valid}, 32'd0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_flags", {29'd0, rd_acq, busy, done}, 32'd0);
        @(posedge clk); #1;

        // Basic tile, one row of the table per cycle
        for (int c = 0; c < 10; c++) begin
            step(tbl[c].s, tbl[c].r, tbl[c].e);
            chk($sformatf("t1_acq_c%0d", c), {31'd0, rd_acq}, {31'd0, tbl[c].acq});
            chk($sformatf("t1_busy_c%0d", c), {31'd0, busy}, {31'd0, tbl[c].bsy});
            chk($sformatf("t1_done_c%0d", c), {31'd0, done}, {31'd0, tbl[c].dn});
            chk($sformatf("t1_valid_c%0d", c), {28'd0, out_valid}, {28'd0, tbl[c].vld});
            chk($sformatf("t1_data_c%0d", c), out_data, tbl[c].dat);
            finish_step();
        end

        // Bubble in cycle 2
        do_reset();
        run_pattern(11, 32'h1, 32'h7FB, 32'h7FF);
        chk("t2_acq", acq_m, 32'h3A);
        chk("t2_done", done_m, 32'h200);
        chk("t2_bubble", {28'd0, obs_valid[3][0], obs_valid[4][1], obs_valid[5][2], obs_valid[6][3]}, 32'd0);
        chk("t2_valid_c4", {28'd0, obs_valid[4]}, 32'h5);
        chk("t2_data_c4", obs_data[4], 32'h00020010);
        chk("t2_valid_c9", {28'd0, obs_valid[9]}, 32'h8);
        chk("t2_data_c9", obs_data[9], 32'h33000000);

        // Stall cycles 3-4
        do_reset();
        run_pattern(12, 32'h1, 32'hFFF, 32'hFE7);
        chk("t3_acq", acq_m, 32'h66);
        chk("t3_done", done_m, 32'h400);
        for (int c = 3; c <= 5; c++) begin
            chk($sformatf("t3_frozen_valid_c%0d", c), {28'd0, obs_valid[c]}, 32'h3);
            chk($sformatf("t3_frozen_data_c%0d", c), obs_data[c], 32'h00000110);
        end

        // Start re-pulsed mid tile, then held for a back-to-back tile
        do_reset();
        run_pattern(12, 32'h9, 32'hFFF, 32'hFFF);
        chk("t4a_acq", acq_m, 32'h1E);
        chk("t4a_done", done_m, 32'h100);
        do_reset();
        run_pattern(11, 32'h1FF, 32'h7FF, 32'h7FF);
        chk("t4b_acq", acq_m, 32'h61E);
        chk("t4b_done", done_m, 32'h100);

        // Asynchronous reset in cycle 3
        do_reset();
        step(1, 1, 1); finish_step();
        step(0, 1, 1); finish_step();
        step(0, 1, 1); finish_step();
        start = 1'b0; rd_rdy = 1'b1; out_en = 1'b1; rd_data = mk_vec(vec_idx);
        #2;
        chk("t5_acq_before", {31'd0, rd_acq}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_flags_in_reset", {30'd0, rd_acq, busy}, 32'd0);
        chk("t5_valid_in_reset", {28'd0, out_valid}, 32'd0);
        chk("t5_data_in_reset", out_data, 32'd0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        vec_idx = 0;
        run_pattern(10, 32'h0, 32'h3FF, 32'h3FF);
        chk("t5_no_done", done_m, 32'h0);
        chk("t5_no_acq", acq_m, 32'h0);
        run_pattern(10, 32'h1, 32'h3FF, 32'h3FF);
        chk("t5_acq", acq_m, 32'h1E);
        chk("t5_busy", busy_m, 32'hFE);
        chk("t5_done", done_m, 32'h100);
        chk("t5_data_c5", obs_data[5], 32'h03122130);

        // Random handshakes over 100 tiles with a per-lane scoreboard
        do_reset();
        g_acc = 0; tiles_started = 0; dones = 0; cyc = 0;
        while ((tiles_started < 100 || busy) && cyc < 20000) begin
            s_r = (tiles_started < 100) && !busy;
            r_r = 1'($urandom_range(0, 3) != 0);
            e_r = 1'($urandom_range(0, 3) != 0);
            start = s_r; rd_rdy = r_r; out_en = e_r;
            for (int i = 0; i < 4; i++) rd_data[i*8 +: 8] = {g_acc[5:0], 2'(i)};
            @(negedge clk);
            if (rd_acq && !rd_rdy) begin
                errors++;
                $display("FAIL rnd_acq_without_rdy: got 1 expected 0 at cycle %0d", cyc);
            end
            if (done) dones++;
            for (int i = 0; i < 4; i++) begin
                if (!out_valid[i] && out_data[i*8 +: 8] != 8'h00) begin
                    errors++;
                    $display("FAIL rnd_invalid_nonzero lane %0d: got %h expected 00", i, out_data[i*8 +: 8]);
                end
                if (out_en && out_valid[i]) begin
                    checks++;
                    if (q_lane[i].size() == 0) begin
                        errors++;
                        $display("FAIL rnd_extra lane %0d: got %h expected none", i, out_data[i*8 +: 8]);
                    end else begin
                        exp_e = q_lane[i].pop_front();
                        if (out_data[i*8 +: 8] !== exp_e) begin
                            errors++;
                            $display("FAIL rnd_lane%0d: got %h expected %h", i, out_data[i*8 +: 8], exp_e);
                        end
                    end
                end
            end
            if (rd_acq) begin
                for (int i = 0; i < 4; i++) q_lane[i].push_back(rd_data[i*8 +: 8]);
                g_acc++;
            end
            if (s_r && e_r) tiles_started++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            out_en = 1'b1; rd_rdy = 1'b1;
            @(negedge clk);
            if (done) dones++;
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i]) begin
                    checks++;
                    if (q_lane[i].size() == 0) begin
                        errors++;
                        $display("FAIL rnd_flush_extra lane %0d: got %h expected none", i, out_data[i*8 +: 8]);
                    end else begin
                        exp_e = q_lane[i].pop_front();
                        if (out_data[i*8 +: 8] !== exp_e) begin
                            errors++;
                            $display("FAIL rnd_flush_lane%0d: got %h expected %h", i, out_data[i*8 +: 8], exp_e);
                        end
                    end
                end
            end
            @(posedge clk); #1;
        end
        chk("rnd_no_timeout", {31'd0, cyc < 20000}, 32'd1);
        chk("rnd_tiles", 32'(tiles_started), 32'd100);
        chk("rnd_dones", 32'(dones), 32'd100);
        chk("rnd_accepts", 32'(g_acc), 32'd400);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rnd_lane%0d_drained", i), 32'(q_lane[i].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
